// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: assembles 1-3 byte opcodes from program ROM; a 1/2/3-byte instruction is presented 1/2/3 cycles after its fetch starts.
// Holds the instruction (ROM deselected) until ir_ready; jmp_en discards any partial or held instruction.
module instr_fetch #(
    parameter int ADDRWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 CS,
    output logic [ADDRWIDTH-1:0] addr,
    input  logic [7:0]           din,
    input  logic                 jmp_en,
    input  logic [ADDRWIDTH-1:0] jmp_addr,
    input  logic                 ir_ready,
    output logic                 ir_valid,
    output logic [7:0]           opcode,
    output logic [7:0]           op1,
    output logic [7:0]           op2,
    output logic [1:0]           ilen,
    output logic [ADDRWIDTH-1:0] pc_next
);

    typedef enum logic [1:0] {S_OP, S_B1, S_B2, S_HOLD} state_t;

    localparam logic [ADDRWIDTH-1:0] ADDR_ONE = {{(ADDRWIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [7:0]           opcode_q, opcode_d;
    logic [7:0]           op1_q, op1_d;
    logic [7:0]           op2_q, op2_d;
    logic [1:0]           ilen_q, ilen_d;
    logic [1:0]           len_dec;

    // 8051-style length table; everything not listed (including reserved A5) is one byte.
    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [1:0] len;
        if (op inside {8'h02, 8'h12, 8'h10, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
                       8'h75, 8'h85, 8'h90, [8'hB4:8'hBF], 8'hD5}) begin
            len = 2'd3;
        end else if ((op[4:0] == 5'b00001) ||
                     (op inside {8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42,
                                 8'h44, 8'h45, 8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62,
                                 8'h64, 8'h65, 8'h70, 8'h72, 8'h74, [8'h76:8'h7F], 8'h80,
                                 8'h82, [8'h86:8'h8F], 8'h92, 8'h94, 8'h95, 8'hA0, 8'hA2,
                                 [8'hA6:8'hAF], 8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0,
                                 8'hD2, [8'hD8:8'hDF], 8'hE5, 8'hF5})) begin
            len = 2'd2;
        end else begin
            len = 2'd1;
        end
        return len;
    endfunction

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        ilen_d   = ilen_q;
        len_dec  = decode_len(din);

        if (jmp_en) begin
            state_d = S_OP;
            addr_d  = jmp_addr;
        end else begin
            case (state_q)
                S_OP: begin
                    opcode_d = din;
                    op1_d    = 8'h00;
                    op2_d    = 8'h00;
                    ilen_d   = len_dec;
                    addr_d   = addr_q + ADDR_ONE;
                    state_d  = (len_dec == 2'd1) ? S_HOLD : S_B1;
                end
                S_B1: begin
                    op1_d   = din;
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = (ilen_q == 2'd2) ? S_HOLD : S_B2;
                end
                S_B2: begin
                    op2_d   = din;
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    // addr already points past the held instruction, so the next fetch needs no bubble.
                    if (ir_ready) begin
                        state_d = S_OP;
                    end
                end
                default: state_d = S_OP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OP;
            addr_q   <= '0;
            opcode_q <= 8'h00;
            op1_q    <= 8'h00;
            op2_q    <= 8'h00;
            ilen_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            ilen_q   <= ilen_d;
        end
    end

    assign ir_valid = (state_q == S_HOLD);
    assign CS       = (state_q == S_HOLD);
    assign addr     = addr_q;
    assign pc_next  = addr_q;
    assign opcode   = opcode_q;
    assign op1      = op1_q;
    assign op2      = op2_q;
    assign ilen     = ilen_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed ROM images, expected instructions queued at issue,
// a negedge monitor pops and compares every newly presented instruction.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       CS;
    logic [7:0] addr;
    logic [7:0] din;
    logic       jmp_en;
    logic [7:0] jmp_addr;
    logic       ir_ready;
    logic       ir_valid;
    logic [7:0] opcode, op1, op2;
    logic [1:0] ilen;
    logic [7:0] pc_next;

    logic [7:0]  rom [256];
    logic [33:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        seen     = 1'b0;

    instr_fetch #(.ADDRWIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .CS       (CS),
        .addr     (addr),
        .din      (din),
        .jmp_en   (jmp_en),
        .jmp_addr (jmp_addr),
        .ir_ready (ir_ready),
        .ir_valid (ir_valid),
        .opcode   (opcode),
        .op1      (op1),
        .op2      (op2),
        .ilen     (ilen),
        .pc_next  (pc_next)
    );

    always #5 clk = ~clk;

    // ROM samples addr on the falling edge; data is ready for the following rising edge.
    always @(negedge clk) din <= rom[addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [33:0] pk(input logic [7:0] o, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [1:0] l,
                                       input logic [7:0] pc);
        return {o, b1, b2, l, pc};
    endfunction

    // Monitor: compare each instruction once, on the first cycle it is presented.
    always @(negedge clk) begin
        if (ir_valid === 1'b1) begin
            if (!seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: got opcode %0h pc_next %0h, expected none", opcode, pc_next);
                end else begin
                    check("sb_instr", {opcode, op1, op2, ilen, pc_next}, exp_q.pop_front());
                end
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (ir_valid !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        check("wait_valid", ir_valid, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_cs", CS, 0);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_fields", {opcode, op1, op2, ilen}, 0);
        check("rst_pc_next", pc_next, 0);
        check("rst_addr", addr, 0);
    endtask

    logic [7:0] dec_op  [9] = '{8'hA5, 8'h21, 8'hB7, 8'hD5, 8'h76, 8'hE5, 8'hC4, 8'hBF, 8'h12};
    logic [1:0] dec_len [9] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd3, 2'd3};

    initial begin
        int n;
        logic [7:0] p;
        logic [7:0] b1, b2;

        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[8'h00] = 8'h01; rom[8'h01] = 8'hC2;
        rom[8'hC2] = 8'h74; rom[8'hC3] = 8'hFF; rom[8'hC4] = 8'h04;
        rom[8'hFE] = 8'h02; rom[8'hFF] = 8'hAB;
        rom[8'h10] = 8'h90; rom[8'h11] = 8'h12; rom[8'h12] = 8'h34;
        rom[8'h50] = 8'h04;

        rst = 1'b1; jmp_en = 1'b0; jmp_addr = 8'h00; ir_ready = 1'b0;
        step(); step();
        check_reset_outputs();

        // Start after reset: AJMP 01 C2 presented on the third cycle.
        exp_q.push_back(pk(8'h01, 8'hC2, 8'h00, 2'd2, 8'h02));
        rst = 1'b0;
        step();
        check("start_not_yet_valid", ir_valid, 0);
        step();
        check("start_valid", ir_valid, 1);
        check("start_cs", CS, 1);

        // Backpressure: everything frozen while ir_ready is low.
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold", {ir_valid, CS, addr, opcode, op1, op2, ilen},
                  {1'b1, 1'b1, 8'h02, 8'h01, 8'hC2, 8'h00, 2'd2});
        end
        exp_q.push_back(pk(8'h00, 8'h00, 8'h00, 2'd1, 8'h03));
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        check("bp_release", {ir_valid, CS, addr}, {1'b0, 1'b0, 8'h02});
        wait_valid(n);
        check("bp_next_cycles", n, 1);

        // Jump from a held instruction.
        exp_q.push_back(pk(8'h74, 8'hFF, 8'h00, 2'd2, 8'hC4));
        exp_q.push_back(pk(8'h04, 8'h00, 8'h00, 2'd1, 8'hC5));
        jmp_en = 1'b1; jmp_addr = 8'hC2;
        step();
        jmp_en = 1'b0;
        check("jmp_clears_valid", {ir_valid, addr}, {1'b0, 8'hC2});
        wait_valid(n);
        check("jmp_2byte_cycles", n, 2);
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        wait_valid(n);
        check("jmp_1byte_cycles", n, 1);

        // Three-byte instruction straddling the address wrap.
        rom[8'h00] = 8'hCD;
        exp_q.push_back(pk(8'h02, 8'hAB, 8'hCD, 2'd3, 8'h01));
        jmp_en = 1'b1; jmp_addr = 8'hFE;
        step();
        jmp_en = 1'b0;
        wait_valid(n);
        check("wrap_cycles", n, 3);

        // Jump during S_B1 of a 3-byte fetch: the 90 instruction must never appear.
        jmp_en = 1'b1; jmp_addr = 8'h10;
        step();
        jmp_en = 1'b0;
        step();
        check("midjmp_in_b1", {ir_valid, addr}, {1'b0, 8'h11});
        exp_q.push_back(pk(8'h04, 8'h00, 8'h00, 2'd1, 8'h51));
        jmp_en = 1'b1; jmp_addr = 8'h50;
        step();
        jmp_en = 1'b0;
        check("midjmp_redirect", {ir_valid, addr}, {1'b0, 8'h50});
        wait_valid(n);

        // jmp_en wins over ir_ready while holding.
        jmp_en = 1'b1; jmp_addr = 8'h10; ir_ready = 1'b1;
        step();
        jmp_en = 1'b0; ir_ready = 1'b0;
        check("jmp_over_ready", {ir_valid, addr}, {1'b0, 8'h10});
        step(); step();
        check("in_b2", {ir_valid, addr}, {1'b0, 8'h12});

        // Reset in S_B2, with a concurrent jump that reset must override.
        rst = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h50;
        step();
        rst = 1'b0; jmp_en = 1'b0;
        check_reset_outputs();
        exp_q.push_back(pk(8'hCD, 8'h00, 8'h00, 2'd1, 8'h01));
        wait_valid(n);
        check("restart_cycles", n, 1);

        // Decode table walk with accept-per-instruction timing.
        p = 8'h20;
        for (int k = 0; k < 9; k++) begin
            b1 = 8'hA0 + 8'(k);
            b2 = 8'hC0 + 8'(k);
            rom[p] = dec_op[k];
            if (dec_len[k] >= 2'd2) rom[p + 8'd1] = b1;
            if (dec_len[k] == 2'd3) rom[p + 8'd2] = b2;
            exp_q.push_back(pk(dec_op[k], (dec_len[k] >= 2'd2) ? b1 : 8'h00,
                               (dec_len[k] == 2'd3) ? b2 : 8'h00, dec_len[k],
                               p + {6'd0, dec_len[k]}));
            p = p + {6'd0, dec_len[k]};
        end
        jmp_en = 1'b1; jmp_addr = 8'h20;
        step();
        jmp_en = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                ir_ready = 1'b1;
                step();
                ir_ready = 1'b0;
            end
            wait_valid(n);
            check("decode_cycles", n, dec_len[k]);
        end

        step(); step();
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: ADDRWIDTH, 8, program-memory address width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: CS  output  1  program-ROM chip select, active low.
REQ-005 SHALL have port: addr  output  ADDRWIDTH  program-ROM byte address (registered).
REQ-006 SHALL have port: din  input  8  ROM data; ROM latches addr on falling clk edge, so the byte for addr is valid at the closing rising edge of the same cycle.
REQ-007 SHALL have port: jmp_en  input  1  redirect fetch to jmp_addr.
REQ-008 SHALL have port: jmp_addr  input  ADDRWIDTH  redirect target.
REQ-009 SHALL have port: ir_ready  input  1  decoder accepts the held instruction.
REQ-010 SHALL have port: ir_valid  output  1  opcode/op1/op2/ilen/pc_next hold a complete instruction.
REQ-011 SHALL have ports: opcode, op1, op2  output  8 each  instruction bytes 0, 1 and 2.
REQ-012 SHALL have port: ilen  output  2  instruction length, 1..3.
REQ-013 SHALL have port: pc_next  output  ADDRWIDTH  address following the held instruction; equals addr while ir_valid=1.

Function
REQ-014 SHALL implement FSM states S_OP, S_B1, S_B2 and S_HOLD; CS=0 in S_OP/S_B1/S_B2 and CS=1 in S_HOLD.
REQ-015 SHALL, in S_OP: capture din into opcode, clear op1/op2, latch ilen from the opcode decode, increment addr, and go to S_HOLD if ilen=1, else to S_B1.
REQ-016 SHALL, in S_B1: capture din into op1, increment addr, and go to S_HOLD if ilen=2, else to S_B2.
REQ-017 SHALL, in S_B2: capture din into op2, increment addr, and go to S_HOLD.
REQ-018 SHALL assert ir_valid exactly while in S_HOLD, holding addr and all instruction fields stable.
REQ-019 SHALL, in S_HOLD with ir_ready=1, go to S_OP and drop ir_valid on that edge; the next fetch starts at the current addr, with no bubble.
REQ-020 SHALL, on jmp_en=1 in any state, load addr<=jmp_addr, go to S_OP, and clear ir_valid; a partial or held instruction is discarded; jmp_en overrides ir_ready.
REQ-021 SHALL increment addr modulo 2^ADDRWIDTH (FF+1 -> 00); an instruction straddling the wrap SHALL assemble normally.
REQ-022 SHALL decode ilen=3 for opcodes: 02, 12, 10, 20, 30, 43, 53, 63, 75, 85, 90, B4-BF, D5.
REQ-023 SHALL decode ilen=2 for opcodes with opcode[4:0]=00001 (AJMP/ACALL) and: 05, 15, 24, 25, 34, 35, 40, 42, 44, 45, 50, 52, 54, 55, 60, 62, 64, 65, 70, 72, 74, 76-7F, 80, 82, 86-8F, 92, 94, 95, A0, A2, A6-AF, B0, B2, C0, C2, C5, D0, D2, D8-DF, E5, F5.
REQ-024 SHALL decode ilen=1 for every other opcode, including reserved A5.
REQ-025 SHALL, at minimum, take 2/3/4 cycles per 1/2/3-byte instruction with ir_ready held high.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, set: state=S_OP, addr=0, CS=0, ir_valid=0, opcode=op1=op2=00, ilen=0, pc_next=0.
REQ-027 SHALL, with rst asserted mid-fetch or in S_HOLD, abandon the instruction; rst has priority over jmp_en and ir_ready.
REQ-028 SHALL begin fetching at address 00 on the first cycle after rst deasserts.

Verification
REQ-029 SHALL verify reset start: ROM 00=01, 01=C2, ir_ready=0 -> 3rd cycle after rst release: ir_valid=1, opcode=01, op1=C2, ilen=2, pc_next=02, CS=1.
REQ-030 SHALL verify jump: jmp_en with jmp_addr=C2, ROM C2=74, C3=FF, C4=04 -> opcode=74, op1=FF, ilen=2, pc_next=C4; after ir_ready -> opcode=04, ilen=1, pc_next=C5.
REQ-031 SHALL verify 3-byte instruction and wrap: jump to FE, ROM FE=02, FF=AB, 00=CD -> opcode=02, op1=AB, op2=CD, ilen=3, pc_next=01.
REQ-032 SHALL verify backpressure: ir_ready=0 for 5 cycles in S_HOLD -> ir_valid, fields, addr constant and CS=1 throughout; ir_ready=1 -> ir_valid=0 next cycle, CS=0.
REQ-033 SHALL verify jump mid-fetch: jmp_en (target 50) during S_B1 of a 90 xx xx fetch -> no ir_valid for the 90 instruction; ROM 50=04 -> opcode=04, pc_next=51.
REQ-034 SHALL verify reset mid-operation: rst pulse during S_B2 -> all outputs equal the REQ-026 values the next cycle; fetch restarts at 00.
